// File: rtl/led_frame_sequencer_if.sv
// rtl/led_frame_sequencer_if.sv - pixel stream between frame sequencer and WS2812 bit encoder
//
// px_data   24  GRB pixel, sequencer -> encoder
// px_valid   1  px_data valid, sequencer -> encoder
// px_ready   1  encoder accepts px_data this cycle, encoder -> sequencer
// enc_busy   1  encoder still shifting the last accepted pixel, encoder -> sequencer

interface led_frame_sequencer_if;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        enc_busy;

    modport master (
        output px_data,
        output px_valid,
        input  px_ready,
        input  enc_busy
    );

    modport slave (
        input  px_data,
        input  px_valid,
        output px_ready,
        output enc_busy
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// rtl/led_frame_sequencer.sv - one WS2812 refresh of the tile matrix per frame_start
//
// Walks the ROWS x COLS on/off matrix row by row, serpentine order (even rows
// left-to-right from column 0, odd rows right-to-left from column COLS-1),
// hands one GRB pixel per handshake to the bit encoder, waits for the encoder
// to finish the last pixel, then times the latch gap.
//
// CLOCK_50     in   1      system clock
// reset_n      in   1      asynchronous active-low reset
// frame_start  in   1      single-cycle refresh request (coalesced while busy)
// row_rd       out  1      read strobe to the state store
// row_addr     out  ROW_W  row being read (0 when row_rd is low)
// row_data     in   COLS   row word, valid the cycle after row_rd
// px           master      pixel stream to the encoder (see led_frame_sequencer_if)
// gap          out  1      latch gap being timed
// busy         out  1      any state other than IDLE
// frame_done   out  1      one-cycle pulse in the IDLE cycle that ends the gap

module led_frame_sequencer #(
    parameter int          ROWS         = 16,
    parameter int          COLS         = 12,
    parameter logic [23:0] ON_COLOR     = 24'h00FF00,
    parameter logic [23:0] OFF_COLOR    = 24'h000000,
    parameter int          RESET_CYCLES = 3000,
    localparam int         ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic                     frame_start,
    output logic                     row_rd,
    output logic [ROW_W-1:0]         row_addr,
    input  logic [COLS-1:0]          row_data,
    led_frame_sequencer_if.master    px,
    output logic                     gap,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int GAP_W = $clog2(RESET_CYCLES + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    logic [2:0]       state_q,   state_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [COL_W-1:0] col_q,     col_d;
    logic [COLS-1:0]  row_reg_q, row_reg_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             pending_q, pending_d;
    logic             done_q,    done_d;

    logic             odd_row;
    logic             last_col;
    logic             last_row;
    logic             px_fire;

    // Odd rows run right-to-left so the chain snakes through the matrix.
    assign odd_row  = row_idx_q[0];
    assign last_col = odd_row ? (col_q == '0) : (col_q == COL_W'(COLS - 1));
    assign last_row = (row_idx_q == ROW_W'(ROWS - 1));
    assign px_fire  = (state_q == ST_SEND) && px.px_ready;

    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_d     = col_q;
        row_reg_d = row_reg_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        // Any request seen while a frame is in flight is remembered once;
        // further requests collapse into the same flag.
        pending_d = pending_q | (frame_start && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (frame_start || pending_q) begin
                    state_d   = ST_FETCH;
                    row_idx_d = '0;
                    pending_d = 1'b0;
                end
            end

            ST_FETCH: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                // Snapshot the row here; later engine writes to it are not seen.
                row_reg_d = row_data;
                col_d     = odd_row ? COL_W'(COLS - 1) : '0;
                state_d   = ST_SEND;
            end

            ST_SEND: begin
                if (px_fire) begin
                    if (last_col) begin
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end else begin
                            row_idx_d = row_idx_q + ROW_W'(1);
                            state_d   = ST_FETCH;
                        end
                    end else if (odd_row) begin
                        col_d = col_q - COL_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end

            ST_DRAIN: begin
                // The latch gap must not start until the last pixel has left the encoder.
                if (!px.enc_busy) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(RESET_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    gap_cnt_d = '0;
                    done_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            row_idx_q <= '0;
            col_q     <= '0;
            row_reg_q <= '0;
            gap_cnt_q <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_q     <= col_d;
            row_reg_q <= row_reg_d;
            gap_cnt_q <= gap_cnt_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

    // Outputs decode straight from registered state, so they hold steady
    // through a stall and drop to zero the instant reset is asserted.
    always_comb begin
        row_rd      = (state_q == ST_FETCH);
        row_addr    = row_rd ? row_idx_q : '0;
        px.px_valid = (state_q == ST_SEND);
        px.px_data  = '0;
        if (state_q == ST_SEND) begin
            px.px_data = row_reg_q[col_q] ? ON_COLOR : OFF_COLOR;
        end
        gap         = (state_q == ST_GAP);
        busy        = (state_q != ST_IDLE);
        frame_done  = done_q;
    end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// tb/tb_led_frame_sequencer.sv - self-checking bench for led_frame_sequencer

module tb_led_frame_sequencer;

    localparam logic [23:0] ON_C  = 24'h00FF00;
    localparam logic [23:0] OFF_C = 24'h000000;
    localparam int          NPIX  = 192;
    localparam int          GAPC  = 3000;

    typedef struct {
        logic [11:0] r0;
        logic [11:0] r1;
        logic [11:0] r2;
        logic [11:0] r15;
        logic [11:0] rest;
        bit          rnd;
        int          exp_on;
        int          exp_first;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic        frame_start;
    logic        row_rd;
    logic [3:0]  row_addr;
    logic [11:0] row_data;
    logic        gap;
    logic        busy;
    logic        frame_done;

    led_frame_sequencer_if px_if();

    led_frame_sequencer dut (
        .CLOCK_50    (clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .row_rd      (row_rd),
        .row_addr    (row_addr),
        .row_data    (row_data),
        .px          (px_if),
        .gap         (gap),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int checks = 0;
    int errors = 0;

    logic [11:0] mem [16];
    bit          rnd_mode = 1'b0;

    logic [23:0] pix_q[$];
    int          addr_q[$];
    int          gap_cyc    = 0;
    int          done_cnt   = 0;
    int          stall_viol = 0;
    int          stall_cnt  = 0;
    int          rd_multi   = 0;
    int          act_cnt    = 0;

    int b_pix, b_addr, b_gap, b_done, b_viol, b_stall, b_multi, b_act;

    vec_t vecs [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // State store: answers a row_rd one cycle later, junk otherwise.
    initial begin : store
        int a;
        row_data = 12'hA5A;
        forever begin
            @(negedge clk);
            if (row_rd) begin
                a = int'(row_addr);
                @(posedge clk);
                #1 row_data = mem[a];
                @(posedge clk);
                #1 row_data = 12'hA5A;
            end
        end
    end

    initial begin
        px_if.px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1 px_if.px_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    initial begin : monitor
        logic        prev_stall;
        logic        prev_rd;
        logic [23:0] prev_data;
        prev_stall = 1'b0;
        prev_rd    = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (px_if.px_valid && px_if.px_ready) pix_q.push_back(px_if.px_data);
            if (prev_stall && reset_n && (!px_if.px_valid || px_if.px_data != prev_data))
                stall_viol++;
            if (px_if.px_valid && !px_if.px_ready) stall_cnt++;
            prev_stall = px_if.px_valid && !px_if.px_ready;
            prev_data  = px_if.px_data;
            if (row_rd) begin
                addr_q.push_back(int'(row_addr));
                if (prev_rd) rd_multi++;
            end
            prev_rd = row_rd;
            if (gap) gap_cyc++;
            if (frame_done) done_cnt++;
            if (row_rd || row_addr != 0 || px_if.px_valid || px_if.px_data != 0 ||
                gap || busy || frame_done) act_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    function automatic logic [23:0] exp_px(input int idx);
        int r, k, c;
        r = idx / 12;
        k = idx % 12;
        c = (r % 2 == 0) ? k : 11 - k;
        return mem[r][c] ? ON_C : OFF_C;
    endfunction

    task automatic snap();
        b_pix   = pix_q.size();
        b_addr  = addr_q.size();
        b_gap   = gap_cyc;
        b_done  = done_cnt;
        b_viol  = stall_viol;
        b_stall = stall_cnt;
        b_multi = rd_multi;
        b_act   = act_cnt;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            @(negedge clk);
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, int'(ok), 1);
    endtask

    task automatic wait_pix(input int target, input string tag);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            if (pix_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_pix_reached"}, int'(ok), 1);
    endtask

    task automatic verify_frame(input string tag, input int base, input int exp_on, input int exp_first);
        int n_on, first, bad;
        logic [23:0] p;
        n_on  = 0;
        first = -1;
        bad   = 0;
        for (int i = 0; i < NPIX && base + i < pix_q.size(); i++) begin
            p = pix_q[base + i];
            if (p == ON_C) begin
                n_on++;
                if (first < 0) first = i;
            end
            if (p != exp_px(i)) bad++;
        end
        check({tag, "_pix_count"}, pix_q.size() - base >= NPIX ? NPIX : pix_q.size() - base, NPIX);
        check({tag, "_on_count"}, n_on, exp_on);
        check({tag, "_first_on"}, first, exp_first);
        check({tag, "_seq_bad"}, bad, 0);
    endtask

    task automatic verify_addrs(input string tag, input int base);
        int bad;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            if (base + i >= addr_q.size() || addr_q[base + i] != i) bad++;
        end
        check({tag, "_row_addr_bad"}, bad, 0);
    endtask

    initial begin
        string tag;
        reset_n        = 1'b0;
        frame_start    = 1'b0;
        px_if.enc_busy = 1'b0;
        for (int r = 0; r < 16; r++) mem[r] = 12'h000;

        //       r0       r1       r2       r15      rest     rnd   on   first
        vecs[0] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 0,   -1};
        vecs[1] = '{12'h001, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0, 1,   0};
        vecs[2] = '{12'h000, 12'h001, 12'h000, 12'h000, 12'h000, 1'b0, 1,   23};
        vecs[3] = '{12'h000, 12'h000, 12'h800, 12'h000, 12'h000, 1'b0, 1,   35};
        vecs[4] = '{12'h000, 12'h000, 12'h000, 12'h001, 12'h000, 1'b0, 1,   191};
        vecs[5] = '{12'h000, 12'h800, 12'h000, 12'h000, 12'h000, 1'b0, 1,   12};
        vecs[6] = '{12'h001, 12'h001, 12'h000, 12'h000, 12'h000, 1'b1, 2,   0};
        vecs[7] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 192, 0};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_px_valid", int'(px_if.px_valid), 0);
        check("rst_px_data", int'(px_if.px_data), 0);
        check("rst_row_rd", int'(row_rd), 0);
        check("rst_gap", int'(gap), 0);
        check("rst_frame_done", int'(frame_done), 0);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Table-driven frames
        for (int v = 0; v < 8; v++) begin
            tag = $sformatf("vec%0d", v);
            for (int r = 0; r < 16; r++) mem[r] = vecs[v].rest;
            mem[0]  = vecs[v].r0;
            mem[1]  = vecs[v].r1;
            mem[2]  = vecs[v].r2;
            mem[15] = vecs[v].r15;
            rnd_mode = vecs[v].rnd;
            snap();
            pulse_start();
            wait_done(tag);
            rnd_mode = 1'b0;
            repeat (3) @(negedge clk);
            verify_frame(tag, b_pix, vecs[v].exp_on, vecs[v].exp_first);
            verify_addrs(tag, b_addr);
            check({tag, "_row_rd_count"}, addr_q.size() - b_addr, 16);
            check({tag, "_row_rd_multi"}, rd_multi - b_multi, 0);
            check({tag, "_gap_cycles"}, gap_cyc - b_gap, GAPC);
            check({tag, "_done_pulses"}, done_cnt - b_done, 1);
            check({tag, "_busy_after"}, int'(busy), 0);
            check({tag, "_stall_stable"}, stall_viol - b_viol, 0);
            if (vecs[v].rnd) check({tag, "_stalls_seen"}, int'(stall_cnt - b_stall > 0), 1);
        end

        // Latency, enc_busy drain and gap timing
        for (int r = 0; r < 16; r++) mem[r] = 12'h000;
        mem[1] = 12'h001;
        px_if.enc_busy = 1'b1;
        snap();
        pulse_start();
        @(negedge clk);
        check("lat_fetch_row_rd", int'(row_rd), 1);
        check("lat_fetch_px_valid", int'(px_if.px_valid), 0);
        @(negedge clk);
        check("lat_wait_px_valid", int'(px_if.px_valid), 0);
        @(negedge clk);
        check("lat_send_px_valid", int'(px_if.px_valid), 1);
        wait_pix(b_pix + NPIX, "drain");
        repeat (100) @(posedge clk);
        #1 px_if.enc_busy = 1'b0;
        @(negedge clk);
        check("drain_gap_low", int'(gap), 0);
        check("drain_busy", int'(busy), 1);
        @(negedge clk);
        check("drain_gap_rise", int'(gap), 1);
        begin
            int n;
            n = 0;
            while (!frame_done && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("drain_gap_to_done", n, GAPC);
        end
        repeat (3) @(negedge clk);
        verify_frame("drain", b_pix, 1, 23);

        // Coalesced requests during a frame
        for (int r = 0; r < 16; r++) mem[r] = 12'h000;
        mem[0] = 12'h001;
        snap();
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (70) @(negedge clk);
        pulse_start();
        wait_pix(b_pix + NPIX, "pend");
        repeat (50) @(negedge clk);
        pulse_start();
        wait_done("pend1");
        check("pend_rd_at_done", int'(row_rd), 0);
        @(negedge clk);
        check("pend_rd_after_done", int'(row_rd), 1);
        check("pend_addr_after_done", int'(row_addr), 0);
        wait_done("pend2");
        repeat (20) @(negedge clk);
        check("pend_busy_after", int'(busy), 0);
        check("pend_done_pulses", done_cnt - b_done, 2);
        check("pend_gap_cycles", gap_cyc - b_gap, 2 * GAPC);
        check("pend_total_pix", pix_q.size() - b_pix, 2 * NPIX);
        verify_frame("pend_f1", b_pix, 1, 0);
        verify_frame("pend_f2", b_pix + NPIX, 1, 0);

        // Asynchronous reset in the middle of a frame
        for (int r = 0; r < 16; r++) mem[r] = 12'hFFF;
        snap();
        pulse_start();
        wait_pix(b_pix + 50, "arst");
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_px_valid", int'(px_if.px_valid), 0);
        check("arst_px_data", int'(px_if.px_data), 0);
        check("arst_row_rd", int'(row_rd), 0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        snap();
        repeat (50) @(negedge clk);
        check("arst_quiet", act_cnt - b_act, 0);
        for (int r = 0; r < 16; r++) mem[r] = 12'h000;
        mem[1] = 12'h001;
        snap();
        pulse_start();
        wait_done("arst_rerun");
        repeat (3) @(negedge clk);
        verify_frame("arst_rerun", b_pix, 1, 23);
        verify_addrs("arst_rerun", b_addr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
